// File: rtl/xif_offload_ctrl_pkg.sv
// xif_offload_ctrl_pkg: shared types and constants for the custom-instruction offload controller
//   XIF_ID_WIDTH : default width of the issue/result id tag
//   xif_id_t     : id tag type
//   xif_state_t  : controller states
//   OPCODE_CNTB  : major opcode of the CNTB custom instruction
package xif_offload_ctrl_pkg;
  localparam int XIF_ID_WIDTH = 4;
  localparam logic [6:0] OPCODE_CNTB = 7'b0001011;
  typedef logic [XIF_ID_WIDTH-1:0] xif_id_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RES, WB} xif_state_t;
endpackage

// File: rtl/xif_offload_ctrl_if.sv
// xif_offload_ctrl_if: decode, issue, result, register-file and status signals of the offload controller
//   off_*    : decode-stage instruction handoff and pipeline flush (kill)
//   issue_*  : issue handshake toward the coprocessor
//   result_* : result return from the coprocessor
//   rf_*     : integer register-file write port
//   stall/illegal/done (+ timeout with XIF_OFFLOAD_TIMEOUT_EN) : status toward the pipeline
//   modport master : controller side; modport slave : environment side
interface xif_offload_ctrl_if #(parameter int ID_WIDTH = 4);
  logic off_valid, off_ready, kill;
  logic [31:0] off_instr, off_rs0, off_rs1;
  logic issue_valid, issue_ready, issue_accept, issue_writeback;
  logic [31:0] issue_instr, issue_rs0, issue_rs1;
  logic [ID_WIDTH-1:0] issue_id;
  logic result_valid;
  logic [ID_WIDTH-1:0] result_id;
  logic [31:0] result_data;
  logic [4:0] result_rd;
  logic rf_we;
  logic [4:0] rf_waddr;
  logic [31:0] rf_wdata;
  logic stall, illegal, done;
`ifdef XIF_OFFLOAD_TIMEOUT_EN
  logic timeout;
`endif
  modport master(
    input off_valid, off_instr, off_rs0, off_rs1, kill,
    input issue_ready, issue_accept, issue_writeback,
    input result_valid, result_id, result_data, result_rd,
    output off_ready, issue_valid, issue_instr, issue_rs0, issue_rs1, issue_id,
    output rf_we, rf_waddr, rf_wdata, stall, illegal, done
`ifdef XIF_OFFLOAD_TIMEOUT_EN
    , output timeout
`endif
  );
  modport slave(
    output off_valid, off_instr, off_rs0, off_rs1, kill,
    output issue_ready, issue_accept, issue_writeback,
    output result_valid, result_id, result_data, result_rd,
    input off_ready, issue_valid, issue_instr, issue_rs0, issue_rs1, issue_id,
    input rf_we, rf_waddr, rf_wdata, stall, illegal, done
`ifdef XIF_OFFLOAD_TIMEOUT_EN
    , input timeout
`endif
  );
endinterface

// File: rtl/xif_offload_ctrl.sv
// xif_offload_ctrl: CPU-side initiator that issues one custom instruction to a coprocessor and writes back its result
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : xif_offload_ctrl_if.master (decode handoff, issue, result, rf write, stall/illegal/done)
//   XIF_OFFLOAD_TIMEOUT_EN : adds a watchdog (TIMEOUT_CYCLES) and the bus.timeout pulse
module xif_offload_ctrl
  import xif_offload_ctrl_pkg::*;
#(
  parameter int ID_WIDTH = XIF_ID_WIDTH
`ifdef XIF_OFFLOAD_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input logic clk,
  input logic rst_n,
  xif_offload_ctrl_if.master bus
);
  xif_state_t st, st_nx;
  logic [31:0] instr, rs0, rs1, data;
  logic [4:0] rd;
  logic [ID_WIDTH-1:0] id, out_id;
  logic killed, off_acc, hs, res_hit, to;
  assign off_acc = st == IDLE && bus.off_valid && !bus.kill;
  assign hs = st == ISSUE && bus.issue_ready;
  // id already advanced at the handshake, so the outstanding request carries id-1
  assign out_id = id - ID_WIDTH'(1);
  assign res_hit = st == WAIT_RES && bus.result_valid && bus.result_id == out_id;
`ifdef XIF_OFFLOAD_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  assign to = (st == ISSUE || st == WAIT_RES) && cnt == CW'(TIMEOUT_CYCLES);
  assign bus.timeout = to;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (st_nx != st || !(st == ISSUE || st == WAIT_RES)) ? '0 : cnt + CW'(1);
`else
  assign to = 1'b0;
`endif
  always_comb begin
    st_nx = st;
    case (st)
      IDLE: st_nx = off_acc ? ISSUE : IDLE;
      ISSUE: st_nx = hs ? (bus.issue_accept && bus.issue_writeback ? WAIT_RES : IDLE) : (bus.kill ? IDLE : ISSUE);
      WAIT_RES: st_nx = res_hit ? WB : WAIT_RES;
      default: st_nx = IDLE;
    endcase
    if (to) st_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      instr <= '0;
      rs0 <= '0;
      rs1 <= '0;
      data <= '0;
      rd <= '0;
      id <= '0;
      killed <= 1'b0;
    end else begin
      st <= st_nx;
      if (off_acc) begin
        instr <= bus.off_instr;
        rs0 <= bus.off_rs0;
        rs1 <= bus.off_rs1;
      end
      if (hs) id <= id + ID_WIDTH'(1);
      if (res_hit) begin
        data <= bus.result_data;
        rd <= bus.result_rd;
      end
      // a flush during (or at the handshake into) WAIT_RES still drains the result but drops the write
      killed <= st == IDLE ? 1'b0 : killed || (bus.kill && (st == WAIT_RES || hs));
    end
  assign bus.off_ready = st == IDLE;
  assign bus.issue_valid = st == ISSUE;
  assign bus.issue_instr = instr;
  assign bus.issue_rs0 = rs0;
  assign bus.issue_rs1 = rs1;
  assign bus.issue_id = id;
  assign bus.rf_we = st == WB && rd != 5'd0 && !killed;
  assign bus.rf_waddr = rd;
  assign bus.rf_wdata = data;
  assign bus.stall = st != IDLE;
  assign bus.illegal = hs && !bus.issue_accept && !to;
  assign bus.done = (hs && bus.issue_accept && !bus.issue_writeback && !to) || st == WB;
endmodule

// File: tb/tb_xif_offload_ctrl.sv
// tb_xif_offload_ctrl: randomized self-checking bench for xif_offload_ctrl against a per-transaction model
module tb_xif_offload_ctrl;
  import xif_offload_ctrl_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  xif_offload_ctrl_if #(.ID_WIDTH(4)) bus();
  xif_offload_ctrl #(
    .ID_WIDTH(4)
`ifdef XIF_OFFLOAD_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int errors = 0, checks = 0;
  int cyc_n = 0, n_we, n_done, n_ill, n_stall, n_to, we_cyc, to_cyc;
  logic [4:0] w_rd;
  logic [31:0] w_data;
  logic [3:0] exp_id;
  always @(posedge clk) cyc_n++;
  always @(negedge clk) begin
    if (bus.rf_we) begin n_we++; w_rd = bus.rf_waddr; w_data = bus.rf_wdata; we_cyc = cyc_n; end
    if (bus.done) n_done++;
    if (bus.illegal) n_ill++;
    if (bus.stall) n_stall++;
`ifdef XIF_OFFLOAD_TIMEOUT_EN
    if (bus.timeout) begin n_to++; to_cyc = cyc_n; end
`endif
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic cyc();
    @(posedge clk); #1;
  endtask
  task automatic clr();
    n_we = 0; n_done = 0; n_ill = 0; n_stall = 0; n_to = 0; we_cyc = -1; to_cyc = -1;
  endtask
  task automatic idle_inputs();
    bus.off_valid = 0; bus.kill = 0; bus.off_instr = 0; bus.off_rs0 = 0; bus.off_rs1 = 0;
    bus.issue_ready = 0; bus.issue_accept = 0; bus.issue_writeback = 0;
    bus.result_valid = 0; bus.result_id = 0; bus.result_data = 0; bus.result_rd = 0;
  endtask
  task automatic present(input logic [31:0] a, input logic [31:0] b, output logic [31:0] ins);
    ins = $urandom();
    ins[6:0] = OPCODE_CNTB;
    bus.off_valid = 1; bus.off_instr = ins; bus.off_rs0 = a; bus.off_rs1 = b;
  endtask
  // Full offload; expectations come from the transaction parameters alone.
  task automatic offload(input string nm, input logic [31:0] a, input logic [31:0] b, input int rdy_dly,
                         input bit acc, input bit wb, input int res_dly, input bit wrong,
                         input logic [4:0] rd, input logic [31:0] data);
    logic [31:0] ins;
    logic [3:0] iid;
    int t0, exp_stall, exp_we;
    bit stable;
    clr();
    t0 = cyc_n;
    present(a, b, ins);
    cyc();
    bus.off_valid = 0; bus.off_instr = $urandom(); bus.off_rs0 = $urandom(); bus.off_rs1 = $urandom();
    iid = exp_id;
    checks++;
    if (bus.issue_valid !== 1'b1 || bus.issue_id !== iid || bus.issue_instr !== ins || bus.issue_rs0 !== a || bus.issue_rs1 !== b) begin
      errors++;
      $display("FAIL %s issue: valid=%b id=%h instr=%h rs0=%h rs1=%h, expected 1 %h %h %h %h",
               nm, bus.issue_valid, bus.issue_id, bus.issue_instr, bus.issue_rs0, bus.issue_rs1, iid, ins, a, b);
    end
    stable = 1;
    repeat (rdy_dly) begin
      cyc();
      if (bus.issue_valid !== 1'b1 || bus.issue_instr !== ins || bus.issue_rs0 !== a || bus.issue_rs1 !== b || bus.issue_id !== iid) stable = 0;
    end
    if (rdy_dly > 0) begin
      checks++;
      if (!stable) begin errors++; $display("FAIL %s hold: issue fields changed before handshake, expected stable for %0d cycles", nm, rdy_dly); end
    end
    bus.issue_ready = 1; bus.issue_accept = acc; bus.issue_writeback = wb;
    cyc();
    bus.issue_ready = 0; bus.issue_accept = 0; bus.issue_writeback = 0;
    exp_id = exp_id + 1;
    if (acc && wb) begin
      repeat (res_dly) cyc();
      if (wrong) begin
        bus.result_valid = 1; bus.result_id = iid + 4'd1; bus.result_rd = ~rd; bus.result_data = ~data;
        cyc();
      end
      bus.result_valid = 1; bus.result_id = iid; bus.result_rd = rd; bus.result_data = data;
      cyc();
      bus.result_valid = 0; bus.result_id = $urandom(); bus.result_data = $urandom();
      cyc();
    end
    exp_stall = 1 + rdy_dly + ((acc && wb) ? res_dly + int'(wrong) + 2 : 0);
    exp_we = (acc && wb && rd != 0) ? 1 : 0;
    checks++;
    if (n_we !== exp_we) begin errors++; $display("FAIL %s rf_we count: got %0d, expected %0d", nm, n_we, exp_we); end
    if (exp_we == 1) begin
      checks++;
      if (w_rd !== rd || w_data !== data || we_cyc !== t0 + exp_stall) begin
        errors++;
        $display("FAIL %s rf write: waddr=%0d wdata=%h cycle=%0d, expected %0d %h %0d", nm, w_rd, w_data, we_cyc, rd, data, t0 + exp_stall);
      end
    end
    checks++;
    if (n_done !== int'(acc) || n_ill !== int'(!acc)) begin
      errors++;
      $display("FAIL %s pulses: done=%0d illegal=%0d, expected %0d %0d", nm, n_done, n_ill, int'(acc), int'(!acc));
    end
    checks++;
    if (n_stall !== exp_stall || bus.off_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s stall/ready: stall cycles=%0d off_ready=%b, expected %0d 1", nm, n_stall, bus.off_ready, exp_stall);
    end
  endtask
  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) cyc();
    checks++;
    if (bus.off_ready !== 1'b1 || bus.stall !== 1'b0 || bus.issue_valid !== 1'b0 || bus.rf_we !== 1'b0 ||
        bus.done !== 1'b0 || bus.illegal !== 1'b0 || bus.issue_id !== 4'd0 || bus.issue_instr !== 32'd0 ||
        bus.issue_rs0 !== 32'd0 || bus.issue_rs1 !== 32'd0 || bus.rf_waddr !== 5'd0 || bus.rf_wdata !== 32'd0) begin
      errors++;
      $display("FAIL reset: ready=%b stall=%b ivalid=%b we=%b done=%b ill=%b id=%h instr=%h, expected 1 0 0 0 0 0 0 0",
               bus.off_ready, bus.stall, bus.issue_valid, bus.rf_we, bus.done, bus.illegal, bus.issue_id, bus.issue_instr);
    end
    @(negedge clk); rst_n = 1;
    cyc();
    exp_id = 0;
  endtask
  task automatic test_latency();
    offload("cntb", 32'hFF000000, 32'd31, 0, 1, 1, 0, 0, 5'd5, 32'd8);
  endtask
  task automatic test_hold();
    offload("hold4", $urandom(), $urandom(), 4, 1, 1, 1, 0, 5'd12, $urandom());
  endtask
  task automatic test_illegal();
    offload("illegal", $urandom(), $urandom(), 1, 0, 1, 0, 0, 5'd3, 32'd1);
  endtask
  task automatic test_no_wb();
    offload("no_wb", $urandom(), $urandom(), 2, 1, 0, 0, 0, 5'd3, 32'd1);
  endtask
  task automatic test_wrong_id();
    offload("wrong_id", $urandom(), $urandom(), 0, 1, 1, 2, 1, 5'd9, 32'hCAFEF00D);
    offload("rd0", $urandom(), $urandom(), 0, 1, 1, 0, 0, 5'd0, 32'hDEAD);
  endtask
  task automatic test_kill_idle();
    logic [31:0] ins;
    clr();
    present(1, 2, ins);
    bus.kill = 1;
    cyc();
    bus.off_valid = 0; bus.kill = 0;
    checks++;
    if (bus.stall !== 1'b0 || bus.issue_valid !== 1'b0) begin
      errors++; $display("FAIL kill_idle: stall=%b issue_valid=%b, expected 0 0", bus.stall, bus.issue_valid);
    end
  endtask
  task automatic test_kill_issue();
    logic [31:0] ins;
    clr();
    present($urandom(), $urandom(), ins);
    cyc();
    bus.off_valid = 0; bus.kill = 1;
    cyc();
    bus.kill = 0;
    checks++;
    if (bus.issue_valid !== 1'b0 || bus.off_ready !== 1'b1 || bus.issue_id !== exp_id || n_done !== 0 || n_ill !== 0) begin
      errors++;
      $display("FAIL kill_issue: issue_valid=%b off_ready=%b id=%h done=%0d illegal=%0d, expected 0 1 %h 0 0",
               bus.issue_valid, bus.off_ready, bus.issue_id, n_done, n_ill, exp_id);
    end
  endtask
  task automatic test_kill_wait(input bit at_hs);
    logic [31:0] ins;
    logic [3:0] iid;
    clr();
    present($urandom(), $urandom(), ins);
    cyc();
    bus.off_valid = 0;
    iid = exp_id;
    bus.issue_ready = 1; bus.issue_accept = 1; bus.issue_writeback = 1; bus.kill = at_hs;
    cyc();
    bus.issue_ready = 0; bus.issue_accept = 0; bus.issue_writeback = 0;
    exp_id = exp_id + 1;
    bus.kill = !at_hs;
    cyc();
    bus.kill = 0;
    cyc();
    bus.result_valid = 1; bus.result_id = iid; bus.result_rd = 5'd7; bus.result_data = 32'h1234;
    cyc();
    bus.result_valid = 0;
    cyc();
    checks++;
    if (n_we !== 0 || n_done !== 1 || bus.off_ready !== 1'b1 || n_stall !== 5) begin
      errors++;
      $display("FAIL kill_wait(at_hs=%0d): rf_we=%0d done=%0d off_ready=%b stall=%0d, expected 0 1 1 5",
               at_hs, n_we, n_done, bus.off_ready, n_stall);
    end
  endtask
  task automatic test_back_to_back();
    offload("b2b_a", $urandom(), $urandom(), 0, 1, 1, 0, 0, 5'd1, 32'h11111111);
    offload("b2b_b", $urandom(), $urandom(), 0, 1, 1, 0, 0, 5'd2, 32'h22222222);
  endtask
  task automatic test_random();
    for (int i = 0; i < 40; i++)
      offload("random", $urandom(), $urandom(), $urandom_range(0, 3), $urandom_range(0, 3) != 0,
              $urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 1) == 1,
              5'($urandom_range(0, 31)), $urandom());
  endtask
`ifdef XIF_OFFLOAD_TIMEOUT_EN
  task automatic test_timeout();
    logic [31:0] ins;
    int e;
    clr();
    present($urandom(), $urandom(), ins);
    cyc();
    bus.off_valid = 0;
    bus.issue_ready = 1; bus.issue_accept = 1; bus.issue_writeback = 1;
    cyc();
    bus.issue_ready = 0; bus.issue_accept = 0; bus.issue_writeback = 0;
    exp_id = exp_id + 1;
    e = cyc_n;
    for (int i = 0; i < 20 && n_to == 0; i++) cyc();
    checks++;
    if (n_to !== 1 || to_cyc !== e + 8 || bus.stall !== 1'b0 || n_we !== 0) begin
      errors++;
      $display("FAIL timeout: pulses=%0d at=%0d stall=%b rf_we=%0d, expected 1 %0d 0 0", n_to, to_cyc, bus.stall, n_we, e + 8);
    end
  endtask
`endif
  task automatic test_async_reset();
    logic [31:0] ins;
    logic [3:0] iid;
    clr();
    present(32'hA5A5A5A5, 32'h5A5A5A5A, ins);
    cyc();
    bus.off_valid = 0;
    iid = exp_id;
    bus.issue_ready = 1; bus.issue_accept = 1; bus.issue_writeback = 1;
    cyc();
    bus.issue_ready = 0; bus.issue_accept = 0; bus.issue_writeback = 0;
    #2 rst_n = 0;
    #1;
    checks++;
    if (bus.off_ready !== 1'b1 || bus.stall !== 1'b0 || bus.issue_valid !== 1'b0 || bus.issue_id !== 4'd0 ||
        bus.issue_instr !== 32'd0 || bus.issue_rs0 !== 32'd0 || bus.rf_we !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: ready=%b stall=%b ivalid=%b id=%h instr=%h rs0=%h we=%b done=%b, expected 1 0 0 0 0 0 0 0",
               bus.off_ready, bus.stall, bus.issue_valid, bus.issue_id, bus.issue_instr, bus.issue_rs0, bus.rf_we, bus.done);
    end
    @(negedge clk); rst_n = 1;
    exp_id = 0;
    clr();
    bus.result_valid = 1; bus.result_id = iid; bus.result_rd = 5'd4; bus.result_data = 32'h77;
    cyc();
    bus.result_valid = 0;
    repeat (2) cyc();
    checks++;
    if (n_we !== 0 || n_done !== 0 || bus.stall !== 1'b0) begin
      errors++; $display("FAIL stale_result: rf_we=%0d done=%0d stall=%b, expected 0 0 0", n_we, n_done, bus.stall);
    end
  endtask
  initial begin
    test_reset();
    test_latency();
    test_hold();
    test_illegal();
    test_no_wb();
    test_wrong_id();
    test_kill_idle();
    test_kill_issue();
    test_kill_wait(0);
    test_kill_wait(1);
    test_back_to_back();
    test_random();
`ifdef XIF_OFFLOAD_TIMEOUT_EN
    test_timeout();
`endif
    test_async_reset();
    offload("post_reset", $urandom(), $urandom(), 1, 1, 1, 1, 0, 5'd31, $urandom());
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/xif_offload_ctrl.md
Name: xif_offload_ctrl

Overview:
- CPU-side initiator for the custom-instruction issue/result interface.
- Accepts one decoded custom instruction plus operands from the decode stage.
- Drives the issue handshake toward the coprocessor (e.g. the CNTB execution unit), then waits for the result.
- Writes the result to the integer register file and stalls the pipeline while an offload is in flight; one outstanding instruction max.

Parameters:
- ID_WIDTH, 4, width of instruction id tagged on issue and matched on result
- TIMEOUT_CYCLES, 64, watchdog limit in cycles (used only with the optional feature)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- off_valid_i  in  1  decode presents a custom instruction
- off_ready_o  out  1  controller can take an instruction (state IDLE)
- off_instr_i  in  32  instruction word
- off_rs0_i  in  32  operand rs1 value
- off_rs1_i  in  32  operand rs2 value
- kill_i  in  1  pipeline flush
- issue_valid_o  out  1  issue request valid
- issue_ready_i  in  1  coprocessor ready (handshake completes when valid&&ready)
- issue_instr_o  out  32  latched instruction
- issue_rs0_o  out  32  latched operand 0
- issue_rs1_o  out  32  latched operand 1
- issue_id_o  out  ID_WIDTH  id of current request
- issue_accept_i  in  1  coprocessor accepts instruction (sampled at handshake)
- issue_writeback_i  in  1  coprocessor will return a result (sampled at handshake)
- result_valid_i  in  1  result present
- result_id_i  in  ID_WIDTH  result id
- result_data_i  in  32  result value
- result_rd_i  in  5  destination register
- rf_we_o  out  1  register-file write enable (1-cycle pulse)
- rf_waddr_o  out  5  write address
- rf_wdata_o  out  32  write data
- stall_o  out  1  pipeline stall (high whenever state != IDLE)
- illegal_o  out  1  1-cycle pulse: instruction rejected (accept=0)
- done_o  out  1  1-cycle pulse: offload retired

Behaviour:
- Reset: state IDLE, id counter 0, all outputs 0 except off_ready_o=1; latched instr/operands cleared to 0.
- States: IDLE, ISSUE, WAIT_RES, WB.
- IDLE:
  - off_valid_i&&off_ready_o latches instr/rs0/rs1, next cycle state ISSUE.
  - off_ready_o is combinationally (state==IDLE).
- ISSUE:
  - issue_valid_o=1; instr/operands/id held stable until handshake.
  - On issue_valid_o&&issue_ready_i, sample accept/writeback:
    - accept=0: illegal_o pulse, go IDLE.
    - accept=1, writeback=0: done_o pulse, go IDLE.
    - accept=1, writeback=1: go WAIT_RES.
  - id increments (mod 2^ID_WIDTH) on every completed handshake.
- WAIT_RES:
  - Ignore result_valid_i unless result_id_i == issue_id_o of the outstanding request.
  - On match: latch data and rd, go WB.
- WB:
  - rf_we_o=1 for exactly one cycle with latched rd/data, except rd==0 (write suppressed).
  - done_o pulse, go IDLE.
  - Earliest next off_valid_i acceptance is the following cycle.
- kill_i:
  - In ISSUE before handshake: issue_valid_o drops next cycle, go IDLE, no pulses. If kill_i and handshake coincide, handshake wins and kill applies as below.
  - In WAIT_RES: set a sticky killed flag; still wait for the matching result (protocol drain), then go IDLE without rf_we_o. done_o still pulses.
  - In IDLE: blocks off_valid_i acceptance that cycle.
- Latency for a 1-cycle coprocessor (ready at first ISSUE cycle, result next cycle): off handshake at T, issue at T+1, result T+2, rf_we_o T+3.
- Async reset mid-operation returns to IDLE immediately; any pending result is discarded.

Optional Feature:
- Macro XIF_OFFLOAD_TIMEOUT_EN.
- Defined:
  - Counter runs in ISSUE and WAIT_RES; reaching TIMEOUT_CYCLES forces IDLE.
  - Extra output port timeout_o (1 bit) pulses one cycle on expiry; no register write.
  - Counter clears on every state change.
- Undefined: no counter, no timeout_o port; controller waits indefinitely.

Decomposition:
- custom_instr_pkg gains a state enum type for this block and an xif id typedef (logic [ID_WIDTH-1:0] default 4).
- custom_instr_pkg reuses OPCODE_CNTB.
- No sub-module needed. Optionally, xif_offload_timer holds the watchdog counter (only under the macro).

Test Plan:
- CNTB rs0=0xFF000000, rs1=31, coprocessor ready after 1 cycle, result 8 rd=5 -> rf_we_o once, waddr 5, wdata 8, stall_o high exactly 3 cycles.
- Coprocessor issue_ready_i delayed 4 cycles -> issue_valid_o held and issue_instr_o/rs0/rs1 constant all 4 cycles; handshake on cycle 5.
- accept=0 at handshake -> illegal_o 1-cycle pulse, no rf_we_o, off_ready_o high next cycle.
- Result arrives with wrong id (id+1) then correct id -> first ignored, second written; result_rd_i=0 -> no rf_we_o but done_o pulses.
- kill_i asserted in WAIT_RES, result 0x1234 rd=7 arrives 2 cycles later -> no rf_we_o, done_o pulse, returns IDLE; kill_i in ISSUE pre-handshake -> issue_valid_o low next cycle.
- With XIF_OFFLOAD_TIMEOUT_EN, TIMEOUT_CYCLES=8, no result ever -> timeout_o pulse 8 cycles after WAIT_RES entry; async reset in WAIT_RES -> all outputs 0, off_ready_o=1.
